// File: rtl/demux1x2_4bit_buf.sv
// 1-to-2 demultiplexer routing 4-bit words into two independent 2-entry FIFOs.
// Each channel presents its head word with a valid/ready handshake and reports occupancy.
module demux1x2_4bit_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out0_data,
  output logic       out0_valid,
  input  logic       out0_ready,
  output logic [3:0] out1_data,
  output logic       out1_valid,
  input  logic       out1_ready,
  output logic [1:0] occ0,
  output logic [1:0] occ1
);

  logic [1:0]      ch_ready;
  logic [1:0]      ch_blocked;
  logic [1:0]      ch_valid;
  logic [1:0][3:0] ch_data;
  logic [1:0][1:0] ch_occ;

  assign ch_ready = {out1_ready, out0_ready};

  // A full channel still accepts when it pops in the same cycle.
  assign in_ready = !reset && !ch_blocked[in_sel];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam logic SEL = 1'(g);

    logic [3:0] mem_q [2];
    logic [3:0] mem_d [2];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] occ_q, occ_d;
    logic       push, pop;

    assign pop           = (occ_q != '0) && ch_ready[g];
    assign push          = in_valid && in_ready && (in_sel == SEL);
    assign ch_blocked[g] = (occ_q == 2'd2) && !pop;

    always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (push) begin
        mem_d[wptr_q] = in_data;
        wptr_d        = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q  <= '{default: '0};
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
        occ_q  <= '0;
      end else begin
        mem_q  <= mem_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        occ_q  <= occ_d;
      end
    end

    assign ch_valid[g] = (occ_q != '0);
    assign ch_data[g]  = (occ_q != '0) ? mem_q[rptr_q] : '0;
    assign ch_occ[g]   = occ_q;
  end

  assign out0_data  = ch_data[0];
  assign out0_valid = ch_valid[0];
  assign out1_data  = ch_data[1];
  assign out1_valid = ch_valid[1];
  assign occ0       = ch_occ[0];
  assign occ1       = ch_occ[1];

endmodule

// File: tb/tb_demux1x2_4bit_buf.sv
// Bench for demux1x2_4bit_buf: per-channel queue model checked every cycle,
// directed scenarios with literal expectations, then a random push/pop run.
module tb_demux1x2_4bit_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [3:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [1:0] occ0;
  logic [1:0] occ1;

  int n_checks = 0;
  int n_fail   = 0;

  demux1x2_4bit_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .occ0      (occ0),
    .occ1      (occ1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, outputs derived from queue contents.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic       model_ok = 1'b0;

  always @(negedge clk) begin
    int  sz_sel;
    logic pop_sel, exp_rdy, p0, p1;
    sz_sel  = in_sel ? q1.size() : q0.size();
    pop_sel = in_sel ? (out1_ready && q1.size() != 0) : (out0_ready && q0.size() != 0);
    exp_rdy = !reset && (sz_sel < 2 || pop_sel);
    if (model_ok) begin
      check("in_ready",   32'(in_ready),   32'(exp_rdy));
      check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      check("out0_data",  32'(out0_data),  (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
      check("occ0",       32'(occ0),       32'(q0.size()));
      check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      check("out1_data",  32'(out1_data),  (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
      check("occ1",       32'(occ1),       32'(q1.size()));
    end
    if (reset) begin
      q0.delete();
      q1.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      p0 = out0_ready && q0.size() != 0;
      p1 = out1_ready && q1.size() != 0;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    logic held;
    reset = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    tick(); tick();
    neg();
    check("rst out0_valid", 32'(out0_valid), 32'd0);
    check("rst out0_data",  32'(out0_data),  32'd0);
    check("rst occ0",       32'(occ0),       32'd0);
    check("rst occ1",       32'(occ1),       32'd0);
    check("rst in_ready",   32'(in_ready),   32'd0);

    // Single push into channel 0
    tick(); reset = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hA;
    neg(); check("first push ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    neg();
    check("p1 out0_valid", 32'(out0_valid), 32'd1);
    check("p1 out0_data",  32'(out0_data),  32'hA);
    check("p1 occ0",       32'(occ0),       32'd1);
    check("p1 out1_valid", 32'(out1_valid), 32'd0);
    check("p1 occ1",       32'(occ1),       32'd0);

    // Fill channel 1, then push into it while it pops
    tick(); in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h3;
    tick(); in_data = 4'h5;
    tick(); in_data = 4'h7;
    neg();
    check("full in_ready", 32'(in_ready), 32'd0);
    check("full occ1",     32'(occ1),     32'd2);
    tick(); out1_ready = 1'b1;
    neg();
    check("full+pop in_ready", 32'(in_ready),  32'd1);
    check("order 1st",         32'(out1_data), 32'h3);
    tick(); in_valid = 1'b0;
    neg();
    check("order 2nd",   32'(out1_data), 32'h5);
    check("pushpop occ", 32'(occ1),      32'd2);
    tick();
    neg();
    check("order 3rd", 32'(out1_data), 32'h7);
    check("drain occ", 32'(occ1),      32'd1);
    tick(); out1_ready = 1'b0;
    neg();
    check("ch1 empty valid", 32'(out1_valid), 32'd0);

    // Drain channel 0, refill to full, push to channel 1 only
    tick(); out0_ready = 1'b1;
    tick(); out0_ready = 1'b0;
    neg(); check("ch0 drained", 32'(occ0), 32'd0);
    tick(); in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
    tick(); in_data = 4'h2;
    tick(); in_sel = 1'b1; in_data = 4'h9;
    neg();
    check("other ch ready", 32'(in_ready), 32'd1);
    check("ch0 full",       32'(occ0),     32'd2);
    tick(); in_valid = 1'b0;
    neg();
    check("iso occ1",      32'(occ1),      32'd1);
    check("iso out1_data", 32'(out1_data), 32'h9);
    check("iso occ0",      32'(occ0),      32'd2);
    check("iso out0_data", 32'(out0_data), 32'h1);

    // Reset with buffered words and an offered push
    tick(); reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hF;
    tick(); reset = 1'b0; in_valid = 1'b0;
    neg();
    check("rst2 out0_valid", 32'(out0_valid), 32'd0);
    check("rst2 out1_valid", 32'(out1_valid), 32'd0);
    check("rst2 out0_data",  32'(out0_data),  32'd0);
    check("rst2 occ0",       32'(occ0),       32'd0);
    check("rst2 occ1",       32'(occ1),       32'd0);

    // Alternating channels with both consumers always ready
    tick(); out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
    tick(); in_sel = 1'b1; in_data = 4'h2;
    neg();
    check("alt out0 1", 32'(out0_data), 32'h1);
    check("alt occ0",   32'(occ0),      32'd1);
    tick(); in_sel = 1'b0; in_data = 4'h3;
    neg();
    check("alt out0 gone", 32'(out0_valid), 32'd0);
    check("alt out1 2",    32'(out1_data),  32'h2);
    tick(); in_sel = 1'b1; in_data = 4'h4;
    neg(); check("alt out0 3", 32'(out0_data), 32'h3);
    tick(); in_valid = 1'b0;
    neg();
    check("alt out1 4",  32'(out1_data), 32'h4);
    check("alt occ0 0",  32'(occ0),      32'd0);

    // Random stress; the producer holds an unaccepted word
    for (int i = 0; i < 10000; i++) begin
      neg();
      held = in_valid && !in_ready && !reset;
      tick();
      reset = ($urandom_range(0, 299) == 0);
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom_range(0, 15));
      end
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
    end
    tick(); reset = 1'b0; in_valid = 1'b0;
    tick(); tick();
    neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
